// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
package loader_pkg;
  typedef enum logic [2:0] {IDLE, HDR0, HDR1, LOAD, WRITE, DONE} state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int HDR_BYTES      = 2;
  localparam int WIDX_W         = 16;
endpackage

// File: rtl/instr_loader_word_assembler.sv
// Little-endian byte placement register: k-th load lands in byte lane k.
module word_assembler
  import loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        load_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        last_o,
  output logic        full_o
);
  logic [BYTES_PER_WORD-1:0][7:0] lane_q;
  logic [1:0]                     cnt_q;
  logic                           full_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      lane_q <= '0;
      cnt_q  <= '0;
      full_q <= 1'b0;
    end else if (load_i) begin
      for (int k = 0; k < BYTES_PER_WORD; k++)
        if (cnt_q == 2'(k)) lane_q[k] <= byte_i;
      cnt_q  <= cnt_q + 2'd1;
      full_q <= (cnt_q == 2'(BYTES_PER_WORD - 1));
    end
  end

  assign word_o = lane_q;
  assign last_o = (cnt_q == 2'(BYTES_PER_WORD - 1));
  assign full_o = full_q;
endmodule

// File: rtl/instr_loader.sv
// Boot loader: parses a length-prefixed byte stream into imem writes and
// holds the core in reset until the whole program has been consumed.
module instr_loader
  import loader_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [7:0]            rx_data_i,
  input  logic                  rx_valid_i,
  output logic                  rx_ready_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [WIDTH-1:0]      mem_wdata_o,
  output logic                  cpu_rst_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  overflow_o
);
  localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);

  state_e              state_q, state_d;
  logic [WIDX_W-1:0]   n_q, n_d;
  logic [WIDX_W-1:0]   widx_q, widx_d;
  logic                ovf_q, ovf_d;
  logic                accept, in_range;
  logic                asm_clr, asm_load, asm_last, asm_full;
  logic [31:0]         asm_word;

  word_assembler u_asm (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (asm_clr),
    .load_i (asm_load),
    .byte_i (rx_data_i),
    .word_o (asm_word),
    .last_o (asm_last),
    .full_o (asm_full)
  );

  assign rx_ready_o = (state_q == HDR0) || (state_q == HDR1) || (state_q == LOAD);
  assign accept     = rx_valid_i && rx_ready_o;
  // widx_q keeps counting past capacity, so writes beyond DEPTH never alias low memory
  assign in_range   = {16'd0, widx_q} < 32'(DEPTH);

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    widx_d   = widx_q;
    ovf_d    = ovf_q;
    asm_clr  = 1'b0;
    asm_load = 1'b0;
    case (state_q)
      IDLE, DONE: if (start_i) begin
        state_d = HDR0;
        widx_d  = '0;
        ovf_d   = 1'b0;
        asm_clr = 1'b1;
      end
      HDR0: if (accept) begin
        n_d[7:0] = rx_data_i;
        state_d  = HDR1;
      end
      HDR1: if (accept) begin
        n_d[15:8] = rx_data_i;
        state_d   = ({rx_data_i, n_q[7:0]} == 16'd0) ? DONE : LOAD;
      end
      LOAD: begin
        asm_load = accept;
        if (accept && asm_last) state_d = WRITE;
      end
      WRITE: begin
        widx_d = widx_q + 16'd1;
        if (!in_range) ovf_d = 1'b1;
        state_d = (widx_q + 16'd1 == n_q) ? DONE : LOAD;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      n_q     <= '0;
      widx_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      widx_q  <= widx_d;
      ovf_q   <= ovf_d;
    end
  end

  assign mem_we_o    = (state_q == WRITE) && in_range && asm_full;
  assign mem_addr_o  = {widx_q[ADDR_WIDTH-3:0], 2'b00};
  assign mem_wdata_o = WIDTH'(asm_word);
  assign cpu_rst_o   = (state_q != DONE);
  assign busy_o      = (state_q == HDR0) || (state_q == HDR1) ||
                       (state_q == LOAD) || (state_q == WRITE);
  assign done_o      = (state_q == DONE);
  assign overflow_o  = ovf_q;
endmodule

// File: tb/tb_instr_loader.sv
// Drives the same stream into a full-size and a 4-word loader and checks
// both against a per-stream list of expected writes.
module tb_instr_loader;
  localparam int DEP_A = 1024;
  localparam int DEP_B = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1, start = 1'b0, rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;

  logic        rdy_a, we_a, crst_a, busy_a, done_a, ovf_a;
  logic [11:0] addr_a;
  logic [31:0] wd_a;
  logic        rdy_b, we_b, crst_b, busy_b, done_b, ovf_b;
  logic [3:0]  addr_b;
  logic [31:0] wd_b;

  instr_loader u_big (
    .clk_i(clk), .rst_i(rst), .start_i(start), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .rx_ready_o(rdy_a), .mem_we_o(we_a), .mem_addr_o(addr_a), .mem_wdata_o(wd_a),
    .cpu_rst_o(crst_a), .busy_o(busy_a), .done_o(done_a), .overflow_o(ovf_a));

  instr_loader #(.ADDR_WIDTH(4)) u_small (
    .clk_i(clk), .rst_i(rst), .start_i(start), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .rx_ready_o(rdy_b), .mem_we_o(we_b), .mem_addr_o(addr_b), .mem_wdata_o(wd_b),
    .cpu_rst_o(crst_b), .busy_o(busy_b), .done_o(done_b), .overflow_o(ovf_b));

  always #5 clk = ~clk;

  int          n_run = 0, n_fail = 0;
  logic [31:0] pay[$];
  logic [63:0] got_a[$], got_b[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (we_a === 1'b1) got_a.push_back({32'(addr_a), wd_a});
    if (we_b === 1'b1) got_b.push_back({32'(addr_b), wd_b});
  end

  task automatic pulse_start;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bp);
    bit acc = 1'b0;
    if (bp) begin
      rx_valid = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    rx_valid = 1'b1;
    rx_data  = b;
    for (int t = 0; t < 50; t++) begin
      acc = rdy_a;
      @(negedge clk);
      if (acc) break;
    end
    chk("accept", {31'd0, acc}, 32'd1);
  endtask

  task automatic check_writes(input string tag, input logic [63:0] got[$], input int dep);
    int exp_n;
    exp_n = (pay.size() < dep) ? pay.size() : dep;
    chk({tag, "_nwr"}, got.size(), exp_n);
    for (int i = 0; i < exp_n && i < got.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i), got[i][63:32], 32'(4 * i));
      chk($sformatf("%s_data%0d", tag, i), got[i][31:0], pay[i]);
    end
  endtask

  task automatic run_stream(input string tag, input bit bp, input bit poke);
    int          n;
    logic [15:0] nn;
    logic [31:0] w;
    n  = pay.size();
    nn = 16'(n);
    got_a.delete();
    got_b.delete();
    pulse_start;
    chk({tag, "_busy0"}, busy_a, 1);
    chk({tag, "_rdy0"},  rdy_a,  1);
    chk({tag, "_crst0"}, crst_a, 1);
    chk({tag, "_ovfa0"}, ovf_a,  0);
    chk({tag, "_ovfb0"}, ovf_b,  0);
    send_byte(nn[7:0], bp);
    send_byte(nn[15:8], bp);
    for (int i = 0; i < n; i++) begin
      w = pay[i];
      for (int k = 0; k < 4; k++) begin
        if (poke && i == 0 && k == 2) begin
          rx_valid = 1'b0;
          pulse_start;
        end
        send_byte(w[8*k +: 8], bp);
      end
    end
    rx_valid = 1'b0;
    if (n > 0) begin
      chk({tag, "_wea_last"}, we_a, (n - 1 < DEP_A));
      chk({tag, "_web_last"}, we_b, (n - 1 < DEP_B));
      chk({tag, "_done_early"}, done_a, 0);
      @(negedge clk);
    end
    chk({tag, "_done_a"}, done_a, 1);
    chk({tag, "_done_b"}, done_b, 1);
    chk({tag, "_crst_a"}, crst_a, 0);
    chk({tag, "_crst_b"}, crst_b, 0);
    chk({tag, "_busy_a"}, busy_a, 0);
    chk({tag, "_ovf_a"},  ovf_a, (n > DEP_A));
    chk({tag, "_ovf_b"},  ovf_b, (n > DEP_B));
    check_writes({tag, "_A"}, got_a, DEP_A);
    check_writes({tag, "_B"}, got_b, DEP_B);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_rdy",  rdy_a,  0);
    chk("rst_we",   we_a,   0);
    chk("rst_addr", addr_a, 0);
    chk("rst_wd",   wd_a,   0);
    chk("rst_crst", crst_a, 1);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_ovf",  ovf_b,  0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy_a, 0);

    pay = '{32'h00A00513, 32'h00100593};
    run_stream("basic", 1'b0, 1'b0);
    pay.delete();
    run_stream("zero", 1'b0, 1'b0);
    pay = '{32'h00A00513, 32'h00100593};
    run_stream("bp", 1'b1, 1'b0);
    pay.delete();
    for (int i = 0; i < 6; i++) pay.push_back($urandom);
    run_stream("ovf", 1'b1, 1'b0);
    pay = '{32'hDEADBEEF};
    run_stream("reload", 1'b0, 1'b1);

    pulse_start;
    send_byte(8'h02, 1'b0); send_byte(8'h00, 1'b0);
    send_byte(8'h13, 1'b0); send_byte(8'h05, 1'b0); send_byte(8'hA0, 1'b0);
    rx_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rdy",  rdy_a,  0);
    chk("mid_we",   we_a,   0);
    chk("mid_crst", crst_a, 1);
    chk("mid_busy", busy_a, 0);
    chk("mid_done", done_a, 0);
    chk("mid_wd",   wd_a,   0);
    pay = '{32'h00A00513, 32'h00100593};
    run_stream("after_rst", 1'b0, 1'b0);

    for (int r = 0; r < 4; r++) begin
      pay.delete();
      repeat ($urandom_range(0, 7)) pay.push_back($urandom);
      run_stream($sformatf("rnd%0d", r), 1'b1, r[0]);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, failed %0d", n_fail);
    $fatal(1);
  end
endmodule
